// File: rtl/tx_eight_ten.sv
// UART transmit framer: start, D0..D7 LSB first, stop at a programmable baud.
// Define TX_PARITY_EN to insert an even-parity bit between D7 and stop.
module tx_eight_ten #(
  parameter int BAUD_W = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BAUD_W-1:0] baud,
  input  logic              tx_valid,
  input  logic [7:0]        tx_data,
  output logic              tx_ready,
  output logic              tx_out,
  output logic              tx_done,
  output logic [3:0]        bit_cnt_out
);

`ifdef TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
  } state_t;
  logic par;
`else
  typedef enum logic [1:0] {
    IDLE, START, DATA, STOP
  } state_t;
`endif

  state_t            state;
  logic [7:0]        shreg;
  logic [BAUD_W-1:0] baud_q;
  logic [BAUD_W-1:0] cnt;
  logic              last;
  logic              one;
  logic              pre_last;

  assign last     = (cnt == baud_q - BAUD_W'(1));
  assign one      = (baud_q == BAUD_W'(1));
  assign pre_last = (cnt + BAUD_W'(2) == baud_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      shreg       <= '0;
      baud_q      <= '0;
      cnt         <= '0;
      tx_ready    <= 1'b1;
      tx_out      <= 1'b1;
      tx_done     <= 1'b0;
      bit_cnt_out <= '0;
`ifdef TX_PARITY_EN
      par         <= 1'b0;
`endif
    end else begin
      tx_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (tx_valid && tx_ready) begin
            shreg       <= tx_data;
            baud_q      <= (baud == '0) ? BAUD_W'(1) : baud;
            cnt         <= '0;
            bit_cnt_out <= 4'd0;
            tx_out      <= 1'b0;
            tx_ready    <= 1'b0;
            state       <= START;
`ifdef TX_PARITY_EN
            par         <= ^tx_data;
`endif
          end
        end
        START: begin
          if (last) begin
            cnt         <= '0;
            bit_cnt_out <= 4'd1;
            tx_out      <= shreg[0];
            state       <= DATA;
          end else begin
            cnt <= cnt + BAUD_W'(1);
          end
        end
        DATA: begin
          if (last) begin
            cnt   <= '0;
            shreg <= shreg >> 1;
            if (bit_cnt_out == 4'd8) begin
`ifdef TX_PARITY_EN
              bit_cnt_out <= 4'd10;
              tx_out      <= par;
              state       <= PARITY;
`else
              bit_cnt_out <= 4'd9;
              tx_out      <= 1'b1;
              tx_done     <= one;
              state       <= STOP;
`endif
            end else begin
              bit_cnt_out <= bit_cnt_out + 4'd1;
              tx_out      <= shreg[1];
            end
          end else begin
            cnt <= cnt + BAUD_W'(1);
          end
        end
`ifdef TX_PARITY_EN
        PARITY: begin
          if (last) begin
            cnt         <= '0;
            bit_cnt_out <= 4'd9;
            tx_out      <= 1'b1;
            tx_done     <= one;
            state       <= STOP;
          end else begin
            cnt <= cnt + BAUD_W'(1);
          end
        end
`endif
        STOP: begin
          if (last) begin
            cnt      <= '0;
            tx_ready <= 1'b1;
            state    <= IDLE;
          end else begin
            // registered pulse must already be high in the final stop cycle
            cnt     <= cnt + BAUD_W'(1);
            tx_done <= pre_last;
          end
        end
        default: begin
          state    <= IDLE;
          tx_ready <= 1'b1;
          tx_out   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tx_eight_ten.sv
// Self-checking bench for tx_eight_ten: queue-based frame model plus
// hand-written waveform pins; honours TX_PARITY_EN when defined.
module tb_tx_eight_ten;
  localparam int BW = 20;
`ifdef TX_PARITY_EN
  localparam int NB = 11;
  localparam logic [10:0] F_A5 = 11'b1_0_10100101_0;
  localparam logic [10:0] F_00 = 11'b1_0_00000000_0;
  localparam logic [10:0] F_81 = 11'b1_0_10000001_0;
  localparam logic [10:0] F_01 = 11'b1_1_00000001_0;
  localparam logic [10:0] F_3C = 11'b1_0_00111100_0;
`else
  localparam int NB = 10;
  localparam logic [10:0] F_A5 = 11'b0_1_10100101_0;
  localparam logic [10:0] F_00 = 11'b0_1_00000000_0;
  localparam logic [10:0] F_81 = 11'b0_1_10000001_0;
  localparam logic [10:0] F_01 = 11'b0_1_00000001_0;
  localparam logic [10:0] F_3C = 11'b0_1_00111100_0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [BW-1:0] baud = '0;
  logic          tx_valid = 1'b0;
  logic [7:0]    tx_data = '0;
  logic          tx_ready;
  logic          tx_out;
  logic          tx_done;
  logic [3:0]    bit_cnt_out;

  int vectors = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tx_eight_ten #(.BAUD_W(BW)) dut (
    .clk(clk),
    .rst(rst),
    .baud(baud),
    .tx_valid(tx_valid),
    .tx_data(tx_data),
    .tx_ready(tx_ready),
    .tx_out(tx_out),
    .tx_done(tx_done),
    .bit_cnt_out(bit_cnt_out)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0h, want %0h", name, $time, act, exp);
    end
  endtask

  typedef struct {
    logic       lvl;
    logic [3:0] idx;
    logic       done;
  } cell_t;

  cell_t q[$];
  bit    cur_idle = 1'b1;

  // One queue entry per clock of the expected line waveform.
  task automatic push_frame(input logic [7:0] d, input logic [BW-1:0] b);
    int   n;
    logic lv[NB];
    int   id[NB];
    n = (b == '0) ? 1 : int'(b);
    lv[0] = 1'b0;
    id[0] = 0;
    for (int i = 0; i < 8; i++) begin
      lv[i+1] = d[i];
      id[i+1] = i + 1;
    end
`ifdef TX_PARITY_EN
    lv[9] = ^d;
    id[9] = 10;
`endif
    lv[NB-1] = 1'b1;
    id[NB-1] = 9;
    for (int k = 0; k < NB; k++)
      for (int j = 0; j < n; j++)
        q.push_back('{lv[k], 4'(id[k]), (k == NB-1) && (j == n-1)});
  endtask

  always @(posedge clk)
    if (rst && cur_idle && tx_valid) push_frame(tx_data, baud);

  always @(negedge rst) begin
    q.delete();
    cur_idle = 1'b1;
  end

  always @(negedge clk) begin
    cell_t c;
    if (!rst) begin
      chk("rst_tx_out", tx_out, 1);
      chk("rst_ready", tx_ready, 1);
      chk("rst_done", tx_done, 0);
      chk("rst_bit_cnt", bit_cnt_out, 0);
      cur_idle = 1'b1;
    end else if (q.size() > 0) begin
      c = q.pop_front();
      chk("m_tx_out", tx_out, c.lvl);
      chk("m_bit_cnt", bit_cnt_out, c.idx);
      chk("m_done", tx_done, c.done);
      chk("m_ready", tx_ready, 0);
      cur_idle = 1'b0;
    end else begin
      chk("m_idle_out", tx_out, 1);
      chk("m_idle_ready", tx_ready, 1);
      chk("m_idle_done", tx_done, 0);
      cur_idle = 1'b1;
    end
  end

  task automatic send(input logic [7:0] d, input int b, input bit keep,
                      output int waited);
    tx_data  = d;
    baud     = BW'(b);
    tx_valid = 1'b1;
    waited   = 0;
    while (1) begin
      @(negedge clk);
      waited++;
      if (tx_ready) break;
      if (waited > 2000) begin
        chk("handshake_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk);
    #1;
    if (!keep) tx_valid = 1'b0;
  endtask

  task automatic capture(input string name, input logic [10:0] bits,
                         input int b, input bit disturb);
    int n;
    int bad;
    int dn;
    int dpos;
    n = (b == 0) ? 1 : b;
    bad = 0;
    dn = 0;
    dpos = -1;
    for (int c = 0; c < NB * n; c++) begin
      @(negedge clk);
      if (tx_out !== bits[c / n]) bad++;
      if (tx_done) begin
        dn++;
        dpos = c;
      end
      if (disturb && c == 6) begin
        #1;
        baud = BW'(7);
        tx_data = 8'hFF;
        tx_valid = 1'b1;
      end
      if (disturb && c == 8) begin
        #1;
        tx_valid = 1'b0;
      end
    end
    chk({name, "_bits_bad"}, bad, 0);
    chk({name, "_done_pos"}, dpos, NB * n - 1);
    chk({name, "_done_cnt"}, dn, 1);
    @(negedge clk);
    chk({name, "_ready_after"}, tx_ready, 1);
    chk({name, "_idle_high"}, tx_out, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int w2;
    int n;
    tx_valid = 1'b1;
    tx_data  = 8'h5A;
    baud     = BW'(1);
    repeat (3) @(negedge clk);
    chk("reset_tx_out", tx_out, 1);
    chk("reset_ready", tx_ready, 1);
    chk("reset_done", tx_done, 0);
    chk("reset_bit_cnt", bit_cnt_out, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    chk("first_accept_out", tx_out, 0);
    chk("first_accept_ready", tx_ready, 0);
    tx_valid = 1'b0;
    repeat (NB + 2) @(negedge clk);

    send(8'hA5, 4, 1'b0, w);
    capture("a5_b4", F_A5, 4, 1'b0);
    send(8'h00, 0, 1'b0, w);
    capture("00_b0", F_00, 0, 1'b0);
    send(8'h00, 1, 1'b0, w);
    capture("00_b1", F_00, 1, 1'b0);

    send(8'h55, 2, 1'b1, w);
    send(8'h0F, 2, 1'b0, w2);
    chk("b2b_period", w2, NB * 2 + 1);
    repeat (NB * 2 + 2) @(negedge clk);

    send(8'h3C, 3, 1'b0, w);
    capture("3c_midchg", F_3C, 3, 1'b1);
    repeat (3) @(negedge clk);

    send(8'h0F, 2, 1'b0, w);
    for (int i = 0; i < 100 && bit_cnt_out != 4'd5; i++) @(negedge clk);
    chk("d4_reached", bit_cnt_out, 5);
    chk("d4_level", tx_out, 0);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_out", tx_out, 1);
    chk("async_rst_ready", tx_ready, 1);
    chk("async_rst_done", tx_done, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    send(8'h81, 2, 1'b0, w);
    capture("81_after_rst", F_81, 2, 1'b0);
    send(8'h01, 3, 1'b0, w);
    capture("01_b3", F_01, 3, 1'b0);

    for (int t = 0; t < 40; t++) begin
      n = int'($urandom_range(0, 5));
      send(8'($urandom), n, ($urandom_range(0, 3) == 0), w);
      if (!tx_valid) repeat ($urandom_range(0, NB * 6)) @(negedge clk);
    end
    tx_valid = 1'b0;
    repeat (NB * 6 + 5) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
